score_keeper: RTL and testbench

Two-player ball-game score keeper that produces the 16-bit packed-BCD word consumed by the 4-digit display scan stage. It synchronises and edge-detects per-player point inputs, then keeps two 2-digit BCD scores. It applies the win-by-margin game rule and freezes the display at game over until a new game is requested. It runs in the 1 kHz display clock domain, directly upstream of the scanner.

---
 rtl/score_pkg.sv | 22 ++
 rtl/score_keeper_if.sv | 24 ++
 rtl/bcd2_counter.sv | 42 ++++
 rtl/score_keeper.sv | 135 +++++++++++++
 tb/tb_score_keeper.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score keeper: winner encoding, FSM state type
// and default game-rule parameters.
package score_pkg;

  // Default game rule: first to 11, win by 2.
  localparam int WIN_SCORE_DEF  = 11;
  localparam int WIN_MARGIN_DEF = 2;

  // Highest score a two-digit BCD counter can show.
  localparam logic [6:0] MAX_SCORE = 7'd99;

  // Winner output encoding.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

endpackage

// File: rtl/score_keeper_if.sv
// Bus between the point/new-game source and the score keeper.
//   point_a, point_b : asynchronous point levels (rising edge = one point)
//   new_game         : synchronous level, clears scores and resumes play
//   score_bcd        : {A tens, A ones, B tens, B ones}
//   game_over        : high while the game is over
//   winner           : 00 none, 01 A, 10 B
interface score_keeper_if;
  logic        point_a;
  logic        point_b;
  logic        new_game;
  logic [15:0] score_bcd;
  logic        game_over;
  logic [1:0]  winner;

  modport master (
    output point_a, point_b, new_game,
    input  score_bcd, game_over, winner
  );

  modport slave (
    input  point_a, point_b, new_game,
    output score_bcd, game_over, winner
  );
endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter with a parallel 7-bit binary copy.
//   clk, reset : clock and asynchronous active-high reset
//   inc        : add one point (ignored while saturated at 99)
//   clr        : synchronous clear to 0, has priority over inc
//   bcd        : {tens, ones}
//   bin        : same value in binary, used for the rule comparisons
//   sat        : high when the count is 99
module bcd2_counter
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] bcd,
  output logic [6:0] bin,
  output logic       sat
);

  assign sat = (bin == MAX_SCORE);

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd <= 8'h00;
      bin <= 7'd0;
    end else if (clr) begin
      bcd <= 8'h00;
      bin <= 7'd0;
    end else if (inc && !sat) begin
      bin <= bin + 7'd1;
      if (bcd[3:0] == 4'd9) begin
        bcd[3:0] <= 4'd0;
        bcd[7:4] <= bcd[7:4] + 4'd1;
      end else begin
        bcd[3:0] <= bcd[3:0] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Two-player score keeper feeding the 4-digit display scanner.
// Synchronises and edge-detects the point inputs, keeps one BCD counter per
// player, applies the win-by-margin rule and freezes at game over until
// new_game.
//   clk_1kHz : display-domain clock, rising edge
//   reset    : asynchronous active-high reset
//   bus      : point/new-game inputs and score/game_over/winner outputs
module score_keeper
  import score_pkg::*;
#(
  parameter int WIN_SCORE  = WIN_SCORE_DEF,
  parameter int WIN_MARGIN = WIN_MARGIN_DEF
) (
  input  logic           clk_1kHz,
  input  logic           reset,
  score_keeper_if.slave  bus
);

  localparam logic [7:0] WS = 8'(WIN_SCORE);
  localparam logic [7:0] WM = 8'(WIN_MARGIN);

  logic sync1_a, sync2_a, prev_a;
  logic sync1_b, sync2_b, prev_b;
  // Marks how far real input samples have propagated since reset:
  // bit 2 set means prev holds a real sample rather than its reset value.
  logic [2:0] sync_valid;

  // NOTE: every flop here, including the synchronisers, resets
  // asynchronously so the whole block is in a known state the moment
  // reset is asserted.
  always_ff @(posedge clk_1kHz or posedge reset) begin
    if (reset) begin
      sync1_a    <= 1'b0;
      sync2_a    <= 1'b0;
      prev_a     <= 1'b0;
      sync1_b    <= 1'b0;
      sync2_b    <= 1'b0;
      prev_b     <= 1'b0;
      sync_valid <= 3'b000;
    end else begin
      sync1_a    <= bus.point_a;
      sync2_a    <= sync1_a;
      prev_a     <= sync2_a;
      sync1_b    <= bus.point_b;
      sync2_b    <= sync1_b;
      prev_b     <= sync2_b;
      sync_valid <= {sync_valid[1:0], 1'b1};
    end
  end

  // An input already high at reset release would look like a 0->1 step
  // against the reset value of prev; only rises between two real samples
  // count.
  logic rise_a, rise_b;
  assign rise_a = sync2_a & ~prev_a & sync_valid[2];
  assign rise_b = sync2_b & ~prev_b & sync_valid[2];

  state_t     state;
  logic       game_over_q;
  logic [1:0] winner_q;

  // A point counts only in PLAY, not on a new_game cycle, and not when both
  // players rise together (void rally).
  logic play_ok, inc_a, inc_b;
  assign play_ok = (state == PLAY) & ~bus.new_game;
  assign inc_a   = play_ok & rise_a & ~rise_b;
  assign inc_b   = play_ok & rise_b & ~rise_a;

  logic [7:0] bcd_a, bcd_b;
  logic [6:0] bin_a, bin_b;
  logic       sat_a, sat_b;

  bcd2_counter u_cnt_a (
    .clk   (clk_1kHz),
    .reset (reset),
    .inc   (inc_a),
    .clr   (bus.new_game),
    .bcd   (bcd_a),
    .bin   (bin_a),
    .sat   (sat_a)
  );

  bcd2_counter u_cnt_b (
    .clk   (clk_1kHz),
    .reset (reset),
    .inc   (inc_b),
    .clr   (bus.new_game),
    .bcd   (bcd_b),
    .bin   (bin_b),
    .sat   (sat_b)
  );

  // Win check on the post-increment score; a point at 99 wins outright.
  // Comparing next >= other + margin avoids a negative difference.
  logic [7:0] next_a, next_b;
  logic       win_a, win_b;
  assign next_a = {1'b0, bin_a} + 8'd1;
  assign next_b = {1'b0, bin_b} + 8'd1;
  assign win_a  = sat_a | ((next_a >= WS) && (next_a >= ({1'b0, bin_b} + WM)));
  assign win_b  = sat_b | ((next_b >= WS) && (next_b >= ({1'b0, bin_a} + WM)));

  always_ff @(posedge clk_1kHz or posedge reset) begin
    if (reset) begin
      state       <= PLAY;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else if (bus.new_game) begin
      state       <= PLAY;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else begin
      case (state)
        PLAY: begin
          if (inc_a && win_a) begin
            state       <= OVER;
            game_over_q <= 1'b1;
            winner_q    <= WIN_A;
          end else if (inc_b && win_b) begin
            state       <= OVER;
            game_over_q <= 1'b1;
            winner_q    <= WIN_B;
          end
        end
        OVER: begin
          // Frozen until new_game.
        end
      endcase
    end
  end

  assign bus.score_bcd = {bcd_a, bcd_b};
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper. Two instances: the default rule
// (11, margin 2) and a margin-9 variant used for the saturation case.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] pa, pb, ng;

  logic [15:0] sc [2];
  logic        go [2];
  logic [1:0]  wn [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_keeper_if if0 ();
  score_keeper_if if1 ();

  assign if0.point_a  = pa[0];
  assign if0.point_b  = pb[0];
  assign if0.new_game = ng[0];
  assign if1.point_a  = pa[1];
  assign if1.point_b  = pb[1];
  assign if1.new_game = ng[1];
  assign sc[0] = if0.score_bcd;
  assign go[0] = if0.game_over;
  assign wn[0] = if0.winner;
  assign sc[1] = if1.score_bcd;
  assign go[1] = if1.game_over;
  assign wn[1] = if1.winner;

  score_keeper dut0 (
    .clk_1kHz (clk),
    .reset    (rst[0]),
    .bus      (if0.slave)
  );

  score_keeper #(.WIN_SCORE(11), .WIN_MARGIN(9)) dut1 (
    .clk_1kHz (clk),
    .reset    (rst[1]),
    .bus      (if1.slave)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Game rules applied to plain integer scores. A point is credited at
  // edge n when the input was sampled low at edge n-3 and high at edge n-2,
  // both samples taken after reset release.
  int         m_ws [2] = '{11, 11};
  int         m_wm [2] = '{2, 9};
  int         m_a  [2];
  int         m_b  [2];
  bit         m_over [2];
  logic [1:0] m_win [2];
  logic [3:0] h_a [2];
  logic [3:0] h_b [2];
  int         n_edge [2];

  task automatic model_reset(input int i);
    m_a[i] = 0; m_b[i] = 0; m_over[i] = 0; m_win[i] = 2'b00;
    h_a[i] = 4'b0; h_b[i] = 4'b0; n_edge[i] = 0;
  endtask

  task automatic model_step(input int i);
    bit ra, rb;
    if (n_edge[i] < 1000) n_edge[i]++;
    h_a[i] = {h_a[i][2:0], pa[i]};
    h_b[i] = {h_b[i][2:0], pb[i]};
    ra = (n_edge[i] >= 4) && h_a[i][2] && !h_a[i][3];
    rb = (n_edge[i] >= 4) && h_b[i][2] && !h_b[i][3];
    if (ng[i]) begin
      m_a[i] = 0; m_b[i] = 0; m_over[i] = 0; m_win[i] = 2'b00;
    end else if (!m_over[i] && (ra != rb)) begin
      if (ra) begin
        if (m_a[i] == 99) begin
          m_over[i] = 1; m_win[i] = 2'b01;
        end else begin
          m_a[i]++;
          if (m_a[i] >= m_ws[i] && m_a[i] - m_b[i] >= m_wm[i]) begin
            m_over[i] = 1; m_win[i] = 2'b01;
          end
        end
      end else begin
        if (m_b[i] == 99) begin
          m_over[i] = 1; m_win[i] = 2'b10;
        end else begin
          m_b[i]++;
          if (m_b[i] >= m_ws[i] && m_b[i] - m_a[i] >= m_wm[i]) begin
            m_over[i] = 1; m_win[i] = 2'b10;
          end
        end
      end
    end
  endtask

  function automatic logic [15:0] to_bcd(input int a, input int b);
    logic [3:0] at, ao, bt, bo;
    at = 4'(a / 10); ao = 4'(a % 10);
    bt = 4'(b / 10); bo = 4'(b % 10);
    return {at, ao, bt, bo};
  endfunction

  always @(posedge clk or posedge rst[0]) begin
    if (rst[0]) model_reset(0);
    else        model_step(0);
  end

  always @(posedge clk or posedge rst[1]) begin
    if (rst[1]) model_reset(1);
    else        model_step(1);
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_score", i), 32'(sc[i]), 32'(to_bcd(m_a[i], m_b[i])));
      check($sformatf("u%0d_over", i), 32'(go[i]), 32'(m_over[i]));
      check($sformatf("u%0d_winner", i), 32'(wn[i]), 32'(m_win[i]));
    end
  end

  // ---------------- stimulus ----------------
  // who: 0 = A, 1 = B, 2 = both
  task automatic pulse(input int i, input int who, input int hi, input int lo);
    @(negedge clk);
    if (who != 1) pa[i] = 1'b1;
    if (who != 0) pb[i] = 1'b1;
    repeat (hi) @(negedge clk);
    pa[i] = 1'b0;
    pb[i] = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic new_game(input int i);
    @(negedge clk);
    ng[i] = 1'b1;
    @(negedge clk);
    ng[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 2'b11;
    pa = 2'b00; pb = 2'b00; ng = 2'b00;
    repeat (3) @(negedge clk);
    rst = 2'b00;
    repeat (4) @(negedge clk);
    check("reset_score", 32'(sc[0]), 32'h0000);
    check("reset_over", 32'(go[0]), 32'h0);
    check("reset_winner", 32'(wn[0]), 32'h0);

    // Single point: update exactly two edges after the first sampling edge.
    pa[0] = 1'b1;
    @(posedge clk); #1 check("pt_edge_k", 32'(sc[0]), 32'h0000);
    @(posedge clk); #1 check("pt_edge_k1", 32'(sc[0]), 32'h0000);
    @(posedge clk); #1 check("pt_edge_k2", 32'(sc[0]), 32'h0100);
    check("pt_over", 32'(go[0]), 32'h0);
    @(negedge clk);
    pa[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Plain win 11-0, then a further point is ignored.
    repeat (10) pulse(0, 0, 3, 3);
    check("win_score", 32'(sc[0]), 32'h1100);
    check("win_over", 32'(go[0]), 32'h1);
    check("win_winner", 32'(wn[0]), 32'h1);
    pulse(0, 0, 3, 3);
    check("over_hold", 32'(sc[0]), 32'h1100);

    // new_game in the same cycle as a point_b rise.
    @(negedge clk);
    pb[0] = 1'b1;
    repeat (2) @(negedge clk);
    ng[0] = 1'b1;
    @(posedge clk); #1;
    check("ng_score", 32'(sc[0]), 32'h0000);
    check("ng_winner", 32'(wn[0]), 32'h0);
    check("ng_over", 32'(go[0]), 32'h0);
    @(negedge clk);
    ng[0] = 1'b0;
    @(negedge clk);
    pb[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("ng_point_dropped", 32'(sc[0]), 32'h0000);

    // Deuce.
    repeat (10) begin
      pulse(0, 0, 3, 3);
      pulse(0, 1, 3, 3);
    end
    check("deuce_1010", 32'(sc[0]), 32'h1010);
    pulse(0, 0, 3, 3); check("deuce_1110", 32'(sc[0]), 32'h1110);
    pulse(0, 1, 3, 3); check("deuce_1111", 32'(sc[0]), 32'h1111);
    pulse(0, 0, 3, 3); check("deuce_1211", 32'(sc[0]), 32'h1211);
    check("deuce_not_over", 32'(go[0]), 32'h0);
    pulse(0, 0, 3, 3); check("deuce_1311", 32'(sc[0]), 32'h1311);
    check("deuce_winner", 32'(wn[0]), 32'h1);

    // Simultaneous rises are void.
    new_game(0);
    repeat (3) pulse(0, 0, 3, 3);
    repeat (5) pulse(0, 1, 3, 3);
    check("simul_before", 32'(sc[0]), 32'h0305);
    pulse(0, 2, 3, 3);
    check("simul_after", 32'(sc[0]), 32'h0305);

    // Reset mid-pulse with point_a held high through release.
    @(negedge clk);
    pa[0] = 1'b1;
    @(negedge clk);
    #2 rst[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_held_high", 32'(sc[0]), 32'h0000);
    pa[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_after_fall", 32'(sc[0]), 32'h0000);
    pulse(0, 0, 3, 3);
    check("rst_then_point", 32'(sc[0]), 32'h0100);

    // Randomised play against the model.
    repeat (300) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)     new_game(0);
      else if (r < 3) pulse(0, 2, $urandom_range(2, 4), $urandom_range(2, 4));
      else if (r < 11) pulse(0, 0, $urandom_range(2, 4), $urandom_range(2, 4));
      else            pulse(0, 1, $urandom_range(2, 4), $urandom_range(2, 4));
    end

    // Saturation on the margin-9 instance: reach 99-95, then A scores.
    repeat (91) begin
      pulse(1, 0, 2, 2);
      pulse(1, 1, 2, 2);
    end
    repeat (8) pulse(1, 0, 2, 2);
    repeat (4) pulse(1, 1, 2, 2);
    check("sat_before", 32'(sc[1]), 32'h9995);
    check("sat_before_over", 32'(go[1]), 32'h0);
    pulse(1, 0, 3, 3);
    check("sat_score", 32'(sc[1]), 32'h9995);
    check("sat_winner", 32'(wn[1]), 32'h1);
    check("sat_over", 32'(go[1]), 32'h1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
